// File: rtl/rr_mux.sv
// rr_mux: N-way, W-bit round-robin arbitrating multiplexer with valid/ready on every port.
// Define RR_MUX_OUT_REG_EN for a one-entry registered output; undefined gives a combinational bypass with grant lock.
module rr_mux #(
  parameter  int NumInp    = 4,
  parameter  int DataWidth = 8,
  localparam int IdxWidth  = $clog2(NumInp)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumInp-1:0]             valid_i,
  output logic [NumInp-1:0]             ready_o,
  input  logic [NumInp*DataWidth-1:0]   data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DataWidth-1:0]          data_o,
  output logic [IdxWidth-1:0]           idx_o
);

  logic [DataWidth-1:0] data_arr [NumInp];
  logic [IdxWidth-1:0]  rr_q;
  logic [IdxWidth-1:0]  rr_next;
  logic [IdxWidth-1:0]  arb_idx;
  logic [IdxWidth-1:0]  grant_idx;
  logic [IdxWidth-1:0]  cand_idx;
  logic                 arb_valid;
  logic                 grant_valid;
  logic                 ready_en;
  logic                 in_fire;
  int                   cand;

  generate
    for (genvar gi = 0; gi < NumInp; gi++) begin : g_chan
      assign data_arr[gi] = data_i[gi*DataWidth +: DataWidth];
      assign ready_o[gi]  = rst_ni & grant_valid & ready_en & (grant_idx == IdxWidth'(gi));
    end
  endgenerate

  // Scan from the farthest candidate back to rr_q so the last hit is the first in priority order.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NumInp - 1; off >= 0; off--) begin
      cand = int'(rr_q) + off;
      if (cand >= NumInp) begin
        cand = cand - NumInp;
      end
      cand_idx = cand[IdxWidth-1:0];
      if (valid_i[cand_idx]) begin
        arb_valid = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign rr_next = (grant_idx == IdxWidth'(NumInp - 1)) ? '0 : grant_idx + 1'b1;
  assign in_fire = grant_valid & ready_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (in_fire) begin
      rr_q <= rr_next;
    end
  end

`ifdef RR_MUX_OUT_REG_EN
  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic [IdxWidth-1:0]  idx_q;

  assign grant_valid = arb_valid;
  assign grant_idx   = arb_idx;
  assign ready_en    = !valid_q | ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (in_fire) begin
      valid_q <= 1'b1;
      data_q  <= data_arr[grant_idx];
      idx_q   <= grant_idx;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;
`else
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;

  // A stalled offer keeps its channel even if a higher-priority source turns valid.
  assign grant_idx   = lock_q ? lock_idx_q : arb_idx;
  assign grant_valid = lock_q ? valid_i[lock_idx_q] : arb_valid;
  assign ready_en    = ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= grant_valid & !ready_i;
      if (grant_valid && !ready_i) begin
        lock_idx_q <= grant_idx;
      end
    end
  end

  assign valid_o = rst_ni & grant_valid;
  assign data_o  = (rst_ni && grant_valid) ? data_arr[grant_idx] : '0;
  assign idx_o   = (rst_ni && grant_valid) ? grant_idx : '0;
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux: a 4-input instance under directed and random traffic, plus a 3-input rotation check.
module tb_rr_mux;
  localparam int N = 4;
  localparam int W = 8;
`ifdef RR_MUX_OUT_REG_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   valid;
  logic [N-1:0]   ready_o;
  logic [N*W-1:0] data;
  logic           valid_o;
  logic           ready_i;
  logic [W-1:0]   data_o;
  logic [1:0]     idx_o;
  logic [W-1:0]   src_data [N];

  logic [2:0]     v3;
  logic [2:0]     rdy3;
  logic [23:0]    d3;
  logic           vo3;
  logic           r3;
  logic [7:0]     do3;
  logic [1:0]     io3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) data[k*W +: W] = src_data[k];
  end

  rr_mux #(.NumInp(4), .DataWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_o), .data_i(data),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .idx_o(idx_o)
  );

  rr_mux #(.NumInp(3), .DataWidth(8)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .ready_o(rdy3), .data_i(d3),
    .valid_o(vo3), .ready_i(r3), .data_o(do3), .idx_o(io3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pending words in grant order, and the round-robin pointer as a plain integer.
  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } word_t;
  word_t      sb [$];
  int         model_ptr = 0;
  bit         offer_active = 1'b0;
  int         offer_ch = 0;
  bit         prev_vo = 1'b0;
  bit         prev_ofire = 1'b0;
  logic [1:0] prev_idx;
  logic [7:0] prev_data;
  logic [N-1:0] taken = '0;
  int         out_count = 0;

  function automatic int model_grant(input logic [N-1:0] v);
    for (int off = 0; off < N; off++) begin
      if (v[(model_ptr + off) % N]) return (model_ptr + off) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    logic  in_fire;
    logic  out_fire;
    int    g;
    int    exp_g;
    word_t w;
    if (!rst_n) begin
      sb.delete();
      model_ptr    = 0;
      offer_active = 1'b0;
      prev_vo      = 1'b0;
      prev_ofire   = 1'b0;
      taken        = '0;
    end else begin
      taken    = valid & ready_o;
      in_fire  = |taken;
      out_fire = valid_o & ready_i;
      g = 0;
      for (int k = 0; k < N; k++) if (taken[k]) g = k;
      check("ready_onehot", 64'($onehot0(ready_o)), 64'd1);
      if (prev_vo && !prev_ofire)
        check("out_hold", {valid_o, idx_o, data_o}, {1'b1, prev_idx, prev_data});
      if (!REG_MODE && !offer_active && (|valid)) begin
        offer_ch     = model_grant(valid);
        offer_active = 1'b1;
      end
      if (in_fire) begin
        exp_g = REG_MODE ? model_grant(valid) : offer_ch;
        check("grant", 64'(g), 64'(exp_g));
        sb.push_back({g[1:0], src_data[g]});
        model_ptr    = (exp_g + 1) % N;
        offer_active = 1'b0;
      end
      if (out_fire) begin
        out_count++;
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          w = sb.pop_front();
          check("out_word", {idx_o, data_o}, {w.idx, w.data});
        end
      end
      prev_vo    = valid_o;
      prev_ofire = out_fire;
      prev_idx   = idx_o;
      prev_data  = data_o;
    end
  end

  // Advance to just after the next rising edge and retire the words that transferred there.
  task automatic step();
    @(posedge clk);
    #1;
    valid = valid & ~taken;
  endtask

  task automatic wait_out(input string name);
    int i = 0;
    @(negedge clk);
    while (!valid_o && i < 20) begin
      step();
      @(negedge clk);
      i++;
    end
    if (!valid_o) check(name, 64'd0, 64'd1);
  endtask

  task automatic drain();
    int i = 0;
    ready_i = 1'b1;
    while ((valid != '0 || sb.size() != 0 || valid_o) && i < 40) begin
      step();
      @(negedge clk);
      i++;
    end
    if (i >= 40) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int got;
    int got_idx [8];
    rst_n   = 1'b0;
    valid   = '0;
    ready_i = 1'b0;
    for (int k = 0; k < N; k++) src_data[k] = '0;
    v3 = '0;
    d3 = {8'hC2, 8'hC1, 8'hC0};
    r3 = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {valid_o, data_o, idx_o, ready_o}, '0);
    end

    // All channels valid, sink always ready: strict rotation with no bubbles.
    step();
    ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin valid[k] = 1'b1; src_data[k] = 8'hA0 + 8'(k); end
    wait_out("rot_timeout");
    for (int i = 0; i < 8; i++) begin
      check("rot_idx", 64'(idx_o), 64'(i % 4));
      check("rot_data", 64'(data_o), 64'(8'hA0 + 8'(i % 4)));
      check("rot_nobubble", 64'(valid_o & ready_i), 64'd1);
      step();
      for (int k = 0; k < N; k++) if (!valid[k]) begin valid[k] = 1'b1; src_data[k] = 8'hA0 + 8'(k); end
      @(negedge clk);
    end
    step();
    drain();

    // Lone channel 2 stalled for three cycles.
    step();
    ready_i = 1'b0;
    valid[2] = 1'b1;
    src_data[2] = 8'h5C;
    wait_out("stall_timeout");
    for (int i = 0; i < 3; i++) begin
      check("stall_word", {valid_o, idx_o, data_o}, {1'b1, 2'd2, 8'h5C});
      step();
      @(negedge clk);
    end
    step();
    ready_i = 1'b1;
    got = out_count;
    repeat (3) step();
    check("stall_one_xfer", 64'(out_count - got), 64'd1);

    // Pointer now 3: channel 3 beats channel 1, holds while channel 0 arrives, then wraps to 0.
    ready_i = 1'b0;
    valid[1] = 1'b1; src_data[1] = 8'h31;
    valid[3] = 1'b1; src_data[3] = 8'h33;
    wait_out("wrap_timeout");
    check("wrap_first", {idx_o, data_o}, {2'd3, 8'h33});
    step();
    valid[0] = 1'b1; src_data[0] = 8'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_word", {valid_o, idx_o, data_o}, {1'b1, 2'd3, 8'h33});
      step();
    end
    ready_i = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got < 2; i++) begin
      @(negedge clk);
      if (valid_o && ready_i) begin got_idx[got] = int'(idx_o); got++; end
      step();
    end
    check("wrap_count", 64'(got), 64'd2);
    check("wrap_order0", 64'(got_idx[0]), 64'd3);
    check("wrap_order1", 64'(got_idx[1]), 64'd0);
    drain();

    // Move the pointer to 1, then reset mid-cycle while channel 2 is on the output.
    step();
    valid[0] = 1'b1; src_data[0] = 8'h40;
    drain();
    step();
    ready_i = 1'b0;
    valid[2] = 1'b1; src_data[2] = 8'h52;
    wait_out("rst_timeout");
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {valid_o, ready_o, data_o, idx_o}, '0);
    valid[0] = 1'b1; src_data[0] = 8'h41;
    ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got < 1; i++) begin
      @(negedge clk);
      if (valid_o && ready_i) begin got_idx[0] = int'(idx_o); got++; end
      step();
    end
    check("rst_first_count", 64'(got), 64'd1);
    check("rst_first_grant", 64'(got_idx[0]), 64'd0);
    drain();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step();
      for (int k = 0; k < N; k++)
        if (!valid[k] && ($urandom_range(0, 1) == 1)) begin valid[k] = 1'b1; src_data[k] = 8'($urandom); end
      ready_i = ($urandom_range(0, 2) != 0);
    end
    step();
    drain();

    // Three-input instance: rotation 0,1,2,0,1,2 with the pointer never reaching 3.
    step();
    v3 = 3'b111;
    got = 0;
    for (int i = 0; i < 20 && got < 6; i++) begin
      @(negedge clk);
      if (vo3 && r3) begin
        check("n3_idx", 64'(io3), 64'(got % 3));
        check("n3_data", 64'(do3), 64'(8'hC0 + 8'(got % 3)));
        got++;
      end
    end
    check("n3_count", 64'(got), 64'd6);
    v3 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
